seq_digit_multiplier: RTL and testbench
=======================================

// Module: seq_digit_multiplier
// PURPOSE
//   Parametrised sequential unsigned multiplier. Successor to the fixed 16x4 add/shift multiplier.
//   - One DIGIT_W-bit multiplier digit is retired per clock, with a merged add+shift step.
//   - Start/Busy/Done handshake; operands are captured at start.
//   - Optional early termination once the remaining multiplier digits are zero.
//   - Sits between operand registers and the result consumer in the arithmetic datapath.
// PARAMETERS
//   MULT_W     16  multiplier width (bits); must be a multiple of DIGIT_W
//   MCAND_W     4  multiplicand width (bits)
//   DIGIT_W     4  multiplier bits consumed per step; step count N = MULT_W/DIGIT_W
//   EARLY_EXIT  0  1: finish as soon as the unprocessed multiplier bits are all zero
// PORTS
//   clock    in   1                clock, rising edge
//   reset    in   1                synchronous, active-high reset
//   St       in   1                start request; sampled only when Busy=0
//   Mult     in   MULT_W           multiplier operand
//   Mcand    in   MCAND_W          multiplicand operand
//   Busy     out  1                high while a multiplication is in progress (RUN)
//   Done     out  1                one-cycle pulse: product valid
//   product  out  MULT_W+MCAND_W   result; held stable until the next accepted St
// BEHAVIOUR
//   - Widths and reset:
//     - PW = MULT_W+MCAND_W. The accumulator and the shifted multiplicand are PW bits wide.
//     - Intermediate sums never overflow PW bits.
//     - When reset=1 at a clock edge: state<=IDLE; Busy, Done, product, accumulator, step counter <= 0.
//     - Reset mid-RUN aborts the operation: no Done is produced and product reads 0.
//   - States: IDLE, RUN, DONE.
//   - IDLE or DONE, St=1: accept. mc_sh<={0,Mcand}; mp_sh<=Mult; acc<=0; cnt<=0; go to RUN.
//     - St=0 in DONE: go to IDLE. St=0 in IDLE: stay.
//   - RUN (Busy=1), every cycle:
//     - acc    <= acc + mc_sh * mp_sh[DIGIT_W-1:0]
//     - mc_sh  <= mc_sh << DIGIT_W
//     - mp_sh  <= mp_sh >> DIGIT_W
//     - cnt    <= cnt + 1
//     - Last step when cnt==N-1, or (EARLY_EXIT=1 and (mp_sh>>DIGIT_W)==0).
//     - On the last step: product <= updated acc; go to DONE.
//     - St is ignored throughout RUN; operand input changes have no effect.
//   - DONE: Done=1 for exactly this cycle; Busy=0.
//     - St may be accepted in this same cycle, giving back-to-back operation with no IDLE cycle.
//   - Latency, with St sampled at edge k:
//     - RUN occupies edges k+1..k+S, where S=N without early exit, 1<=S<=N with early exit.
//     - Done is high in the cycle after edge k+S.
//     - Initiation interval is S+1 cycles.
//   - Mult=0: EARLY_EXIT=1 gives S=1, EARLY_EXIT=0 gives S=N. Either way product=0.
//   - Outputs are registered: Busy=(state==RUN), Done=(state==DONE). No combinational in->out path.
//   - Elaboration must fail (generate-time $error) if MULT_W%DIGIT_W!=0 or DIGIT_W<1.
// TESTING
//   1. Defaults, Mult=16'hFFFF, Mcand=4'hF, 1-cycle St -> Busy 4 cycles; Done pulse 5 cycles after St; product=20'hEFFF1.
//   2. EARLY_EXIT=1, Mult=16'h0003, Mcand=4'h5 -> S=1, Done 2 cycles after St, product=20'h0000F. Same stimulus with EARLY_EXIT=0 -> Done after 5 cycles, same product.
//   3. Mult=0, Mcand=4'h9 -> product=0. S=1 if EARLY_EXIT=1, else S=4.
//   4. St re-pulsed with new operands during RUN -> ignored: first product correct, exactly one Done.
//      St held high through DONE -> second operation starts with no IDLE gap; Done pulses 5 cycles apart.
//   5. reset asserted at the 2nd RUN cycle -> next cycle state IDLE, Busy=0, product=0, no Done.
//      A new St afterwards computes correctly.
//   6. MULT_W=8, MCAND_W=8, DIGIT_W=2, Mult=8'hFF, Mcand=8'hFF -> Busy 4 cycles, product=16'hFE01.
//      Also run 1000 random operand pairs per configuration against a reference a*b model.

Source files
------------

// File: rtl/seq_digit_multiplier_if.sv
// Operand/result bundle between the operand registers and the digit-serial multiplier.
// Latency: none; wires only.
// Backpressure: none; St is only looked at while Busy=0, and Done is a one-cycle pulse.
interface seq_digit_multiplier_if #(
  parameter int MULT_W  = 16,
  parameter int MCAND_W = 4
) ();
  logic                       St;
  logic [MULT_W-1:0]          Mult;
  logic [MCAND_W-1:0]         Mcand;
  logic                       Busy;
  logic                       Done;
  logic [MULT_W+MCAND_W-1:0]  product;

  // Requester drives start/operands and observes status/result.
  modport master (
    output St, Mult, Mcand,
    input  Busy, Done, product
  );

  // Multiplier side.
  modport slave (
    input  St, Mult, Mcand,
    output Busy, Done, product
  );
endinterface

// File: rtl/seq_digit_multiplier.sv
// Unsigned MULT_W x MCAND_W multiplier that retires one DIGIT_W-bit multiplier digit per clock.
// Latency: S run cycles (S=MULT_W/DIGIT_W, or fewer with EARLY_EXIT) plus one Done cycle.
// Backpressure: St is ignored while Busy; a start is accepted in IDLE or in the Done cycle.
module seq_digit_multiplier #(
  parameter int MULT_W     = 16,
  parameter int MCAND_W    = 4,
  parameter int DIGIT_W    = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  seq_digit_multiplier_if.slave bus
);

  localparam int PW    = MULT_W + MCAND_W;
  localparam int N     = (DIGIT_W > 0) ? (MULT_W / DIGIT_W) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject digit sizes that do not tile the multiplier exactly.
  if (DIGIT_W < 1) begin : g_bad_digit
    $error("seq_digit_multiplier: DIGIT_W must be at least 1");
  end else if ((MULT_W % DIGIT_W) != 0) begin : g_bad_ratio
    $error("seq_digit_multiplier: MULT_W must be a multiple of DIGIT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_acc;
  logic [PW-1:0]       r_mc_sh;
  logic [MULT_W-1:0]   r_mp_sh;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [PW-1:0]       r_product;

  logic [DIGIT_W-1:0]  w_digit;
  logic [PW-1:0]       w_partial;
  logic [PW-1:0]       w_acc_nxt;
  logic [MULT_W-1:0]   w_mp_nxt;
  logic                w_last;

  // One merged add+shift step: the multiplicand is pre-shifted to the current digit's weight,
  // so the partial product lands directly in the accumulator without a result shift.
  always_comb begin
    w_digit   = r_mp_sh[DIGIT_W-1:0];
    w_partial = r_mc_sh * PW'(w_digit);
    w_acc_nxt = r_acc + w_partial;
    w_mp_nxt  = r_mp_sh >> DIGIT_W;
    w_last    = (r_cnt == CNT_W'(N - 1)) ||
                ((EARLY_EXIT != 0) && (w_mp_nxt == '0));
  end

  // Control FSM and datapath registers; Busy/Done/product are registered here.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_mc_sh   <= '0;
      r_mp_sh   <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (bus.St) begin
            r_mc_sh <= {{MULT_W{1'b0}}, bus.Mcand};
            r_mp_sh <= bus.Mult;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_nxt;
          r_mc_sh <= r_mc_sh << DIGIT_W;
          r_mp_sh <= w_mp_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_acc_nxt;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy    = r_busy;
  assign bus.Done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_digit_multiplier.sv
// Scoreboard bench for three multiplier configurations driven side by side.
// Latency: expected Done cycle and run length come from a plain-arithmetic model.
// Backpressure: stimulus only starts a new operation when the DUT is idle or in its Done cycle.
module tb_seq_digit_multiplier;

  logic clock;
  logic rst_a;
  logic rst_bc;
  int unsigned cyc;
  int checks;
  int errors;

  // DUT 0: 16x4, digit 4, no early exit; DUT 1: same with early exit; DUT 2: 8x8, digit 2.
  int mw [3] = '{16, 16, 8};
  int cw [3] = '{4, 4, 8};
  int dw [3] = '{4, 4, 2};
  int nn [3] = '{4, 4, 4};
  int ee [3] = '{0, 1, 0};

  seq_digit_multiplier_if #(.MULT_W(16), .MCAND_W(4)) ifa ();
  seq_digit_multiplier_if #(.MULT_W(16), .MCAND_W(4)) ifb ();
  seq_digit_multiplier_if #(.MULT_W(8),  .MCAND_W(8)) ifc ();

  seq_digit_multiplier #(.MULT_W(16), .MCAND_W(4), .DIGIT_W(4), .EARLY_EXIT(0)) u_a (
    .clock(clock), .reset(rst_a), .bus(ifa));
  seq_digit_multiplier #(.MULT_W(16), .MCAND_W(4), .DIGIT_W(4), .EARLY_EXIT(1)) u_b (
    .clock(clock), .reset(rst_bc), .bus(ifb));
  seq_digit_multiplier #(.MULT_W(8), .MCAND_W(8), .DIGIT_W(2), .EARLY_EXIT(0)) u_c (
    .clock(clock), .reset(rst_bc), .bus(ifc));

  typedef struct {
    logic [63:0] prod;
    int unsigned dcyc;
    int          s;
  } exp_t;

  exp_t sb [3][$];
  int   bcnt [3];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic busy_of(int d);
    case (d)
      0: return ifa.Busy;
      1: return ifb.Busy;
      default: return ifc.Busy;
    endcase
  endfunction

  function automatic logic done_of(int d);
    case (d)
      0: return ifa.Done;
      1: return ifb.Done;
      default: return ifc.Done;
    endcase
  endfunction

  function automatic logic [63:0] product_of(int d);
    case (d)
      0: return 64'(ifa.product);
      1: return 64'(ifb.product);
      default: return 64'(ifc.product);
    endcase
  endfunction

  function automatic logic rst_of(int d);
    return (d == 0) ? rst_a : rst_bc;
  endfunction

  // Run length: N steps, or with early exit the first step after which no nonzero
  // multiplier bits remain unprocessed.
  function automatic int steps_ref(int d, logic [63:0] m);
    if (ee[d] == 0) return nn[d];
    for (int s = 1; s < nn[d]; s++)
      if ((m >> (s * dw[d])) == 64'd0) return s;
    return nn[d];
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
    end
  endtask

  task automatic set_ops(input int d, input logic st, input logic [63:0] m, input logic [63:0] c);
    case (d)
      0: begin ifa.St = st; ifa.Mult = m[15:0]; ifa.Mcand = c[3:0]; end
      1: begin ifb.St = st; ifb.Mult = m[15:0]; ifb.Mcand = c[3:0]; end
      default: begin ifc.St = st; ifc.Mult = m[7:0]; ifc.Mcand = c[7:0]; end
    endcase
  endtask

  // Called at a negedge while the DUT can accept; the accepting edge is the next posedge.
  task automatic start(input int d, input logic [63:0] m, input logic [63:0] c,
                       input bit push, input bit keep);
    exp_t e;
    int   s;
    set_ops(d, 1'b1, m, c);
    if (push) begin
      s      = steps_ref(d, m);
      e.prod = m * c;
      e.dcyc = cyc + 1 + s;
      e.s    = s;
      sb[d].push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    if (!keep) set_ops(d, 1'b0, m, c);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (!done_of(d) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout dut%0d waited=%0d cycles required<=%0d", d, n, 200);
    end
  endtask

  task automatic run_op(input int d, input logic [63:0] m, input logic [63:0] c);
    start(d, m, c, 1'b1, 1'b0);
    wait_done(d);
    @(negedge clock);
  endtask

  // Monitor: every Done pulse is matched against the oldest outstanding expectation.
  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_of(d)) bcnt[d] = 0;
      else if (busy_of(d)) bcnt[d]++;
      if (done_of(d)) begin
        if (sb[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d actual=1 expected=0 cycle=%0d", d, cyc);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          chk("product", d, product_of(d), e.prod);
          chk("done_cycle", d, 64'(cyc), 64'(e.dcyc));
          chk("busy_cycles", d, 64'(bcnt[d]), 64'(e.s));
        end
        bcnt[d] = 0;
      end
    end
  end

  initial begin
    logic [63:0] m;
    logic [63:0] c;
    logic [63:0] mmask;
    logic [63:0] cmask;
    int n;
    checks = 0;
    errors = 0;
    cyc    = 0;
    for (int d = 0; d < 3; d++) begin
      bcnt[d] = 0;
      set_ops(d, 1'b0, 64'd0, 64'd0);
    end
    rst_a  = 1'b1;
    rst_bc = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", d, 64'(busy_of(d)), 64'd0);
      chk("reset_done", d, 64'(done_of(d)), 64'd0);
      chk("reset_product", d, product_of(d), 64'd0);
    end
    rst_a  = 1'b0;
    rst_bc = 1'b0;
    @(negedge clock);

    // Directed cases with the spec's literal results.
    run_op(0, 64'hFFFF, 64'hF);
    chk("full_ones_product", 0, product_of(0), 64'hEFFF1);
    run_op(1, 64'h0003, 64'h5);
    chk("early_exit_product", 1, product_of(1), 64'h0000F);
    run_op(0, 64'h0003, 64'h5);
    chk("no_exit_product", 0, product_of(0), 64'h0000F);
    run_op(1, 64'h0, 64'h9);
    chk("zero_mult_ee", 1, product_of(1), 64'h0);
    run_op(0, 64'h0, 64'h9);
    chk("zero_mult", 0, product_of(0), 64'h0);
    run_op(1, 64'hFFFF, 64'hF);
    run_op(2, 64'hFF, 64'hFF);
    chk("w8_product", 2, product_of(2), 64'hFE01);

    // St re-pulsed with new operands mid-run must be ignored.
    start(0, 64'h1234, 64'h7, 1'b1, 1'b0);
    set_ops(0, 1'b1, 64'hFFFF, 64'hF);
    @(negedge clock);
    @(negedge clock);
    set_ops(0, 1'b0, 64'hFFFF, 64'hF);
    wait_done(0);
    @(negedge clock);

    // St held high through DONE: second operation starts with no idle gap.
    start(0, 64'hABCD, 64'h3, 1'b1, 1'b1);
    set_ops(0, 1'b1, 64'h0F0F, 64'hB);
    wait_done(0);
    start(0, 64'h0F0F, 64'hB, 1'b1, 1'b0);
    wait_done(0);
    @(negedge clock);

    // Reset in the second run cycle aborts the operation.
    start(0, 64'h00FF, 64'hE, 1'b0, 1'b0);
    @(negedge clock);
    rst_a = 1'b1;
    @(negedge clock);
    chk("abort_busy", 0, 64'(busy_of(0)), 64'd0);
    chk("abort_done", 0, 64'(done_of(0)), 64'd0);
    chk("abort_product", 0, product_of(0), 64'd0);
    @(negedge clock);
    rst_a = 1'b0;
    repeat (6) @(negedge clock);
    run_op(0, 64'h1111, 64'h2);

    // Random operands, mixing idle gaps and back-to-back starts.
    for (int d = 0; d < 3; d++) begin
      mmask = (64'd1 << mw[d]) - 64'd1;
      cmask = (64'd1 << cw[d]) - 64'd1;
      for (int i = 0; i < 1000; i++) begin
        m = {$urandom, $urandom} & mmask;
        if ($urandom_range(3) == 0) m = m & 64'hFF;
        if ($urandom_range(7) == 0) m = 64'd0;
        c = {$urandom, $urandom} & cmask;
        start(d, m, c, 1'b1, 1'b0);
        wait_done(d);
        if ($urandom_range(1) == 1) @(negedge clock);
      end
      @(negedge clock);
    end

    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    for (int d = 0; d < 3; d++) begin
      if (sb[d].size() != 0) begin
        checks++;
        errors++;
        $display("FAIL missing_done dut%0d outstanding=%0d expected=0", d, sb[d].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
